fft_m1_input_buf: RTL and testbench
===================================

// Module: fft_m1_input_buf
// PURPOSE
// - Ping-pong frame buffer between the module-0 CBFP output and the module-1 butterfly input.
// - Collects 8 beats of 16-lane complex CBFP samples (11b) into one frame of 128 points.
// - Replays each frame as 4 paired beats: port _p carries beat k, port _n carries beat k+4.
// - The pairing matches the x[n] / x[n+N/2] operands the next butterfly needs.
// PARAMETERS
// - ARRAY_SIZE   16  lanes per beat
// - DW           11  sample width, signed two's complement
// - FRAME_BEATS   8  input beats per frame; must be even; read beats = FRAME_BEATS/2
// - IDX_W         5  CBFP index (zero-count) width; used only with FFT_M1_IDX_EN
// - IDX_NUM       4  CBFP indices per beat; used only with FFT_M1_IDX_EN
// PORTS
// - clk        in   1                    clock, rising edge
// - rstn       in   1                    asynchronous active-low reset
// - valid_in   in   1                    din_* carry a valid beat this cycle
// - din_re     in   DW  x ARRAY_SIZE     real part, signed
// - din_im     in   DW  x ARRAY_SIZE     imaginary part, signed
// - idx_in     in   IDX_W x IDX_NUM      CBFP indices for this beat (FFT_M1_IDX_EN only)
// - dout_re_p / dout_im_p  out  DW x ARRAY_SIZE  beat k of the frame
// - dout_re_n / dout_im_n  out  DW x ARRAY_SIZE  beat k+FRAME_BEATS/2 of the frame
// - idx_p / idx_n  out  IDX_W x IDX_NUM  indices matching _p and _n (FFT_M1_IDX_EN only)
// - valid_out  out  1                    dout_* valid this cycle
// - overflow   out  1                    sticky: a beat was dropped with both banks full
// BEHAVIOUR
// - Reset: all dout_*, idx_*, valid_out and overflow go to 0.
//   - wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, both bank_full=0, FSM=IDLE.
//   - Reset mid-frame discards all stored data. No partial frame is ever emitted.
// - Write side:
//   - On each valid_in beat, write to bank[wr_bank][wr_cnt] and increment wr_cnt.
//   - Gaps in valid_in hold wr_cnt. A frame may be non-contiguous.
//   - On the edge that writes beat FRAME_BEATS-1:
//     - set bank_full[wr_bank]
//     - reset wr_cnt to 0
//     - toggle wr_bank
// - Overflow:
//   - Applies when valid_in=1 and bank_full[wr_bank]=1.
//   - The beat is dropped. wr_cnt and wr_bank hold. overflow is set and stays set until rstn.
// - Read FSM (IDLE, READ):
//   - IDLE -> READ when bank_full[rd_bank]=1; rd_cnt=0.
//   - READ, each cycle, registered:
//     - dout_*_p = bank[rd_bank][rd_cnt]
//     - dout_*_n = bank[rd_bank][rd_cnt+FRAME_BEATS/2]
//     - valid_out=1
//     - rd_cnt++
//   - On rd_cnt = FRAME_BEATS/2-1:
//     - clear bank_full[rd_bank] and toggle rd_bank
//     - go to READ (rd_cnt=0) if the other bank is full, else go to IDLE
//   - Outside READ: valid_out=0. dout_* hold their last value.
// - Latency:
//   - Edge t writes the last beat. valid_out first rises at edge t+2.
//   - Output beats are contiguous, FRAME_BEATS/2 cycles per frame.
// - Throughput: back-to-back frames never overflow; a read (4 cycles) finishes before the next fill (8 cycles).
// - Same edge, full set and clear: write fills bank A while read releases bank B.
//   - Both updates take effect.
//   - The FSM continues to A with no idle cycle.
// - Arithmetic: data is passed through bit-exact. No rounding, no saturation, no sign change.
// CONFIGURATION
// - FFT_M1_IDX_EN defined:
//   - Adds idx_in, idx_p and idx_n.
//   - Indices are stored per beat with their data and replayed with identical timing and pairing.
//   - idx_* reset to 0.
// - FFT_M1_IDX_EN undefined: these ports and their storage are not present.
// STRUCTURE
// - fft_m1_pkg holds:
//   - localparams DW, ARRAY_SIZE, FRAME_BEATS, IDX_W, IDX_NUM
//   - typedef sample_t = logic signed [DW-1:0]
//   - typedef beat_t = sample_t [ARRAY_SIZE]
//   - typedef rd_state_e = {IDLE, READ}
// - Sub-module fft_pingpong_bank:
//   - one bank: FRAME_BEATS x beat storage
//   - write port, plus two combinational read ports at offsets k and k+FRAME_BEATS/2
//   - instantiated twice
// - The top holds the write counter, the full flags, the read FSM and the output registers.
// TESTING
// - Single frame: 8 contiguous beats, lane value = beat*16+lane, on re and im.
//   - 4 valid_out beats, starting 2 cycles after the last input beat.
//   - Output k: _p = k*16+lane, _n = (k+4)*16+lane.
// - Back-to-back 3 frames, valid_in held high for 24 cycles:
//   - 12 output beats, grouped 4 per frame.
//   - Data is correct per frame and overflow stays 0.
// - Gapped input: 8 beats with valid_in low every other cycle.
//   - Output is identical to the contiguous case, 2 cycles after the 8th beat.
// - Overflow: read side forced busy (2 frames written before the first read starts) via long test hook.
//   - Alternatively, a 17th beat is injected while both banks are full.
//   - overflow=1 and the beat is dropped. Frames already stored are emitted intact.
// - Reset mid-frame: rstn low after 5 beats, then a fresh 8-beat frame.
//   - Outputs read 0 during reset, and valid_out is never asserted for the partial frame.
//   - The fresh frame is output correctly.
// - With FFT_M1_IDX_EN: idx_in[g] = beat+g.
//   - idx_p[g] = k+g and idx_n[g] = k+4+g, aligned with valid_out.
// - Signed extremes (-1024, +1023) are passed through bit-exact.

Source files
------------

// File: rtl/fft_m1_pkg.sv
// Shared types and sizes for the module-1 input ping-pong buffer.
package fft_m1_pkg;

    localparam int DW          = 11;
    localparam int ARRAY_SIZE  = 16;
    localparam int FRAME_BEATS = 8;
    localparam int HALF_BEATS  = FRAME_BEATS / 2;
    localparam int IDX_W       = 5;
    localparam int IDX_NUM     = 4;
    localparam int WR_CNT_W    = $clog2(FRAME_BEATS);
    localparam int RD_CNT_W    = (HALF_BEATS > 1) ? $clog2(HALF_BEATS) : 1;

    typedef logic signed [DW-1:0] sample_t;
    typedef sample_t beat_t [ARRAY_SIZE];
    typedef logic [IDX_W-1:0] idx_t;
    typedef idx_t idx_beat_t [IDX_NUM];

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_e;

endpackage

// File: rtl/fft_pingpong_bank.sv
// One frame bank: FRAME_BEATS beats of storage, one write port and a paired
// combinational read at beat k and k+FRAME_BEATS/2. FFT_M1_IDX_EN adds index storage.
module fft_pingpong_bank
    import fft_m1_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [WR_CNT_W-1:0] waddr,
    input  beat_t               wr_re,
    input  beat_t               wr_im,
`ifdef FFT_M1_IDX_EN
    input  idx_beat_t           wr_idx,
    output idx_beat_t           rd_idx_p,
    output idx_beat_t           rd_idx_n,
`endif
    input  logic [RD_CNT_W-1:0] raddr,
    output beat_t               rd_re_p,
    output beat_t               rd_im_p,
    output beat_t               rd_re_n,
    output beat_t               rd_im_n
);

    beat_t mem_re [FRAME_BEATS];
    beat_t mem_im [FRAME_BEATS];
    logic [WR_CNT_W-1:0] addr_p;
    logic [WR_CNT_W-1:0] addr_n;

    // Storage is not reset; the owner's full flags decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[waddr] <= wr_re;
            mem_im[waddr] <= wr_im;
        end
    end

    assign addr_p  = WR_CNT_W'(raddr);
    assign addr_n  = addr_p + WR_CNT_W'(HALF_BEATS);
    assign rd_re_p = mem_re[addr_p];
    assign rd_im_p = mem_im[addr_p];
    assign rd_re_n = mem_re[addr_n];
    assign rd_im_n = mem_im[addr_n];

`ifdef FFT_M1_IDX_EN
    idx_beat_t mem_idx [FRAME_BEATS];

    always_ff @(posedge clk) begin
        if (we) mem_idx[waddr] <= wr_idx;
    end

    assign rd_idx_p = mem_idx[addr_p];
    assign rd_idx_n = mem_idx[addr_n];
`endif

endmodule

// File: rtl/fft_m1_input_buf.sv
// Ping-pong frame buffer feeding the module-1 butterfly with x[n] / x[n+N/2] beat pairs.
// Optional macro FFT_M1_IDX_EN carries the CBFP indices alongside the data.
module fft_m1_input_buf
    import fft_m1_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      valid_in,
    input  beat_t     din_re,
    input  beat_t     din_im,
`ifdef FFT_M1_IDX_EN
    input  idx_beat_t idx_in,
    output idx_beat_t idx_p,
    output idx_beat_t idx_n,
`endif
    output beat_t     dout_re_p,
    output beat_t     dout_im_p,
    output beat_t     dout_re_n,
    output beat_t     dout_im_n,
    output logic      valid_out,
    output logic      overflow
);

    logic                wr_bank;
    logic [WR_CNT_W-1:0] wr_cnt;
    logic                rd_bank;
    logic [RD_CNT_W-1:0] rd_cnt;
    logic [1:0]          bank_full;
    rd_state_e           rd_state;

    logic wr_fire, wr_last, rd_last, other_full;

    beat_t bk_re_p [2];
    beat_t bk_im_p [2];
    beat_t bk_re_n [2];
    beat_t bk_im_n [2];
`ifdef FFT_M1_IDX_EN
    idx_beat_t bk_idx_p [2];
    idx_beat_t bk_idx_n [2];
`endif

    assign wr_fire = valid_in && !bank_full[wr_bank];
    assign wr_last = wr_fire && (wr_cnt == WR_CNT_W'(FRAME_BEATS - 1));
    assign rd_last = (rd_state == READ) && (rd_cnt == RD_CNT_W'(HALF_BEATS - 1));
    // A fill completing on the same edge counts, so the reader chains without a bubble.
    assign other_full = bank_full[~rd_bank] || (wr_last && (wr_bank != rd_bank));

    genvar b;
    for (b = 0; b < 2; b++) begin : g_bank
        fft_pingpong_bank u_bank (
            .clk     (clk),
            .we      (wr_fire && (wr_bank == 1'(b))),
            .waddr   (wr_cnt),
            .wr_re   (din_re),
            .wr_im   (din_im),
`ifdef FFT_M1_IDX_EN
            .wr_idx  (idx_in),
            .rd_idx_p(bk_idx_p[b]),
            .rd_idx_n(bk_idx_n[b]),
`endif
            .raddr   (rd_cnt),
            .rd_re_p (bk_re_p[b]),
            .rd_im_p (bk_im_p[b]),
            .rd_re_n (bk_re_n[b]),
            .rd_im_n (bk_im_n[b])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (valid_in && bank_full[wr_bank]) overflow <= 1'b1;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    // Set and clear never target the same bank: a write needs it empty, a read needs it full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_full <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_last && (wr_bank == 1'(i)))      bank_full[i] <= 1'b1;
                else if (rd_last && (rd_bank == 1'(i))) bank_full[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state  <= IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            valid_out <= 1'b0;
            dout_re_p <= '{default: '0};
            dout_im_p <= '{default: '0};
            dout_re_n <= '{default: '0};
            dout_im_n <= '{default: '0};
`ifdef FFT_M1_IDX_EN
            idx_p     <= '{default: '0};
            idx_n     <= '{default: '0};
`endif
        end else begin
            valid_out <= 1'b0;
            case (rd_state)
                IDLE: begin
                    rd_cnt <= '0;
                    if (bank_full[rd_bank]) rd_state <= READ;
                end
                READ: begin
                    dout_re_p <= bk_re_p[rd_bank];
                    dout_im_p <= bk_im_p[rd_bank];
                    dout_re_n <= bk_re_n[rd_bank];
                    dout_im_n <= bk_im_n[rd_bank];
`ifdef FFT_M1_IDX_EN
                    idx_p     <= bk_idx_p[rd_bank];
                    idx_n     <= bk_idx_n[rd_bank];
`endif
                    valid_out <= 1'b1;
                    if (rd_last) begin
                        rd_cnt   <= '0;
                        rd_bank  <= ~rd_bank;
                        rd_state <= other_full ? READ : IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_m1_input_buf.sv
// Directed self-checking bench for fft_m1_input_buf (index path under FFT_M1_IDX_EN).
`timescale 1ns/1ps
module tb_fft_m1_input_buf;
    import fft_m1_pkg::*;

    localparam int PW = ARRAY_SIZE * DW;
    localparam int IW = IDX_NUM * IDX_W;

    logic  clk = 1'b0;
    logic  rstn;
    logic  valid_in;
    beat_t din_re, din_im;
    beat_t dout_re_p, dout_im_p, dout_re_n, dout_im_n;
    logic  valid_out, overflow;
`ifdef FFT_M1_IDX_EN
    idx_beat_t idx_in, idx_p, idx_n;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_m1_input_buf dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .din_re   (din_re),
        .din_im   (din_im),
`ifdef FFT_M1_IDX_EN
        .idx_in   (idx_in),
        .idx_p    (idx_p),
        .idx_n    (idx_n),
`endif
        .dout_re_p(dout_re_p),
        .dout_im_p(dout_im_p),
        .dout_re_n(dout_re_n),
        .dout_im_n(dout_im_n),
        .valid_out(valid_out),
        .overflow (overflow)
    );

    typedef struct {
        int            cyc;
        logic [PW-1:0] re_p, im_p, re_n, im_n;
        logic [IW-1:0] ix_p, ix_n;
    } cap_t;
    cap_t caps[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] pk(beat_t bt);
        logic [PW-1:0] v;
        for (int l = 0; l < ARRAY_SIZE; l++) v[l*DW +: DW] = bt[l];
        return v;
    endfunction

    // mode 0: re=im=beat*16+lane; mode 1: re=base+beat*16+lane, im=~re; mode 2: +/- full scale
    function automatic sample_t fval(int mode, int base, int bt, int l, int im);
        sample_t v;
        case (mode)
            0:       v = sample_t'(bt * 16 + l);
            1:       v = (im != 0) ? ~sample_t'(base + bt * 16 + l) : sample_t'(base + bt * 16 + l);
            default: v = (((l + bt) % 2) == im) ? sample_t'(-1024) : sample_t'(1023);
        endcase
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_pk(int mode, int base, int bt, int im);
        logic [PW-1:0] v;
        for (int l = 0; l < ARRAY_SIZE; l++) v[l*DW +: DW] = fval(mode, base, bt, l, im);
        return v;
    endfunction

    function automatic logic [IW-1:0] exp_ix(int bt);
        logic [IW-1:0] v;
        for (int g = 0; g < IDX_NUM; g++) v[g*IDX_W +: IDX_W] = IDX_W'(bt + g);
        return v;
    endfunction

    always @(negedge clk) begin
        cap_t c;
        if (valid_out) begin
            c.cyc  = cyc;
            c.re_p = pk(dout_re_p);
            c.im_p = pk(dout_im_p);
            c.re_n = pk(dout_re_n);
            c.im_n = pk(dout_im_n);
`ifdef FFT_M1_IDX_EN
            for (int g = 0; g < IDX_NUM; g++) begin
                c.ix_p[g*IDX_W +: IDX_W] = idx_p[g];
                c.ix_n[g*IDX_W +: IDX_W] = idx_n[g];
            end
`else
            c.ix_p = '0;
            c.ix_n = '0;
`endif
            caps.push_back(c);
        end
    end

    task automatic drive_beat(int mode, int base, int bt);
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            din_re[l] = fval(mode, base, bt, l, 0);
            din_im[l] = fval(mode, base, bt, l, 1);
        end
`ifdef FFT_M1_IDX_EN
        for (int g = 0; g < IDX_NUM; g++) idx_in[g] = IDX_W'(bt + g);
`endif
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic send_frame(int mode, int base, int gap, output int last);
        last = 0;
        for (int bt = 0; bt < FRAME_BEATS; bt++) begin
            drive_beat(mode, base, bt);
            last = cyc;
            if (gap != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // t_last < 0 skips the latency check
    task automatic check_frame(string tag, int mode, int base, int first, int t_last);
        for (int k = 0; k < HALF_BEATS; k++) begin
            cap_t c;
            if (first + k >= caps.size()) begin
                chk($sformatf("%s missing beat %0d", tag, k), caps.size(), first + k + 1);
                return;
            end
            c = caps[first + k];
            if (t_last >= 0) chk($sformatf("%s cyc%0d", tag, k), c.cyc, t_last + 2 + k);
            chk($sformatf("%s re_p%0d", tag, k), c.re_p, exp_pk(mode, base, k, 0));
            chk($sformatf("%s im_p%0d", tag, k), c.im_p, exp_pk(mode, base, k, 1));
            chk($sformatf("%s re_n%0d", tag, k), c.re_n, exp_pk(mode, base, k + HALF_BEATS, 0));
            chk($sformatf("%s im_n%0d", tag, k), c.im_n, exp_pk(mode, base, k + HALF_BEATS, 1));
`ifdef FFT_M1_IDX_EN
            chk($sformatf("%s idx_p%0d", tag, k), c.ix_p, exp_ix(k));
            chk($sformatf("%s idx_n%0d", tag, k), c.ix_n, exp_ix(k + HALF_BEATS));
`endif
        end
    endtask

    initial begin
        int t0, t1, t2;
        rstn     = 1'b0;
        valid_in = 1'b0;
        din_re   = '{default: '0};
        din_im   = '{default: '0};
`ifdef FFT_M1_IDX_EN
        idx_in   = '{default: '0};
`endif
        wait_cycles(3);
        chk("reset valid_out", valid_out, 0);
        chk("reset overflow", overflow, 0);
        chk("reset dout_re_p", pk(dout_re_p), 0);
        rstn = 1'b1;
        wait_cycles(1);

        caps.delete();
        send_frame(0, 0, 0, t0);
        wait_cycles(8);
        chk("single count", caps.size(), 4);
        check_frame("single", 0, 0, 0, t0);

        caps.delete();
        send_frame(1, 200, 0, t0);
        send_frame(1, 400, 0, t1);
        send_frame(1, 600, 0, t2);
        wait_cycles(8);
        chk("b2b count", caps.size(), 12);
        check_frame("b2b f0", 1, 200, 0, t0);
        check_frame("b2b f1", 1, 400, 4, t1);
        check_frame("b2b f2", 1, 600, 8, t2);
        chk("b2b overflow", overflow, 0);

        caps.delete();
        send_frame(0, 0, 1, t0);
        wait_cycles(8);
        chk("gap count", caps.size(), 4);
        check_frame("gap", 0, 0, 0, t0);

        caps.delete();
        send_frame(2, 0, 0, t0);
        wait_cycles(8);
        chk("extreme count", caps.size(), 4);
        check_frame("extreme", 2, 0, 0, t0);

        // Hold the reader idle so both banks fill, then push one more beat.
        caps.delete();
        force dut.rd_state = IDLE;
        send_frame(1, 100, 0, t0);
        send_frame(1, 300, 0, t1);
        chk("ovf before", overflow, 0);
        drive_beat(1, 900, 0);
        chk("ovf set", overflow, 1);
        chk("ovf no output while held", caps.size(), 0);
        release dut.rd_state;
        wait_cycles(12);
        chk("ovf count", caps.size(), 8);
        check_frame("ovf A", 1, 100, 0, -1);
        check_frame("ovf B", 1, 300, 4, -1);
        if (caps.size() >= 5) chk("ovf A->B contiguous", caps[4].cyc, caps[3].cyc + 1);
        caps.delete();
        send_frame(1, 500, 0, t0);
        wait_cycles(8);
        chk("post ovf count", caps.size(), 4);
        check_frame("post ovf", 1, 500, 0, t0);
        chk("ovf sticky", overflow, 1);

        caps.delete();
        for (int bt = 0; bt < 5; bt++) drive_beat(1, 700, bt);
        rstn = 1'b0;
        #2;
        chk("midrst dout_re_p", pk(dout_re_p), 0);
        chk("midrst dout_im_n", pk(dout_im_n), 0);
        chk("midrst valid_out", valid_out, 0);
        chk("midrst overflow", overflow, 0);
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(10);
        chk("midrst no partial", caps.size(), 0);
        send_frame(1, 50, 0, t0);
        wait_cycles(8);
        chk("midrst fresh count", caps.size(), 4);
        check_frame("midrst fresh", 1, 50, 0, t0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
